// File: rtl/store_drain_unit_if.sv
// store_drain_if: store-queue, writeback-snoop and memory-write signals of the store drain unit.
package sdu_pkg;
  typedef logic [2:0] id_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [2:0]  fn3;
    logic        forwarded_store;
    logic [31:0] data;
  } sq_entry_t;
  typedef struct packed {
    logic        valid;
    id_t         id;
    logic [31:0] data;
  } wb_packet_t;
endpackage

interface store_drain_if;
  import sdu_pkg::*;
  logic        sq_valid;
  sq_entry_t   sq_entry;
  id_t         sq_forward_id;
  logic        sq_pop;
  wb_packet_t  wb_snoop;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        drain_idle;
  logic        protocol_error;
  modport master (
    output sq_valid, sq_entry, sq_forward_id, wb_snoop, mem_req_ready, mem_ack,
    input  sq_pop, mem_req_valid, mem_addr, mem_be, mem_data, drain_idle, protocol_error
  );
  modport slave (
    input  sq_valid, sq_entry, sq_forward_id, wb_snoop, mem_req_ready, mem_ack,
    output sq_pop, mem_req_valid, mem_addr, mem_be, mem_data, drain_idle, protocol_error
  );
endinterface

// File: rtl/store_drain_unit.sv
// store_drain_unit: turns released store-queue entries into memory write requests with an outstanding-write limit.
// Define CVA5_STORE_FORWARD_SNOOP_EN to take forwarded-store data from the writeback bus.
module store_drain_unit import sdu_pkg::*; #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic rst_n,
  store_drain_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_DATA, REQ} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  out_q, out_d;
  logic        perr_q, perr_d, pop, hs;
`ifdef CVA5_STORE_FORWARD_SNOOP_EN
  logic [2:0]  fn3_q, fn3_d;
  id_t         id_q, id_d;
  logic        hit_new, hit_wait;
  function automatic logic [31:0] lane(input logic [31:0] d, input logic [2:0] f);
    return f[1:0] == 2'b00 ? {4{d[7:0]}} : f[1:0] == 2'b01 ? {2{d[15:0]}} : d;
  endfunction
  assign hit_new  = bus.wb_snoop.valid & (bus.wb_snoop.id == bus.sq_forward_id);
  assign hit_wait = bus.wb_snoop.valid & (bus.wb_snoop.id == id_q);
`endif
  assign pop = rst_n & bus.sq_valid & (state_q == IDLE) & (out_q < 3'(MAX_OUTSTANDING));
  assign hs  = (state_q == REQ) & bus.mem_req_ready;
  assign bus.sq_pop         = pop;
  assign bus.mem_req_valid  = state_q == REQ;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_be         = be_q;
  assign bus.mem_data       = data_q;
  assign bus.drain_idle     = (state_q == IDLE) & (out_q == 3'd0) & !bus.sq_valid;
  assign bus.protocol_error = perr_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
`ifdef CVA5_STORE_FORWARD_SNOOP_EN
    fn3_d   = fn3_q;
    id_d    = id_q;
`endif
    if (pop) begin
      addr_d = bus.sq_entry.addr;
      be_d   = bus.sq_entry.be;
`ifdef CVA5_STORE_FORWARD_SNOOP_EN
      fn3_d   = bus.sq_entry.fn3;
      id_d    = bus.sq_forward_id;
      data_d  = !bus.sq_entry.forwarded_store ? bus.sq_entry.data :
                hit_new ? lane(bus.wb_snoop.data, bus.sq_entry.fn3) : data_q;
      state_d = (!bus.sq_entry.forwarded_store || hit_new) ? REQ : WAIT_DATA;
`else
      data_d  = bus.sq_entry.data;
      state_d = REQ;
`endif
    end
`ifdef CVA5_STORE_FORWARD_SNOOP_EN
    else if (state_q == WAIT_DATA && hit_wait) begin
      data_d  = lane(bus.wb_snoop.data, fn3_q);
      state_d = REQ;
    end
`endif
    else if (hs) state_d = IDLE;
  end
  // A stray ack with nothing in flight leaves the count at zero and latches the error.
  always_comb begin
    out_d  = (hs & !bus.mem_ack) ? out_q + 3'd1 :
             (!hs & bus.mem_ack & (out_q != 3'd0)) ? out_q - 3'd1 : out_q;
    perr_d = perr_q | (bus.mem_ack & !hs & (out_q == 3'd0));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      out_q   <= '0;
      perr_q  <= 1'b0;
`ifdef CVA5_STORE_FORWARD_SNOOP_EN
      fn3_q   <= '0;
      id_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
      out_q   <= out_d;
      perr_q  <= perr_d;
`ifdef CVA5_STORE_FORWARD_SNOOP_EN
      fn3_q   <= fn3_d;
      id_q    <= id_d;
`endif
    end
  end
endmodule

// File: tb/tb_store_drain_unit.sv
// tb_store_drain_unit: directed and random stimulus against a transaction-level model of the store drain unit.
module tb_store_drain_unit;
  import sdu_pkg::*;
  localparam int MAX = 2;
`ifdef CVA5_STORE_FORWARD_SNOOP_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  store_drain_if bus();
  store_drain_unit #(.MAX_OUTSTANDING(MAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  bit          m_held, m_have, m_perr;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_be;
  logic [2:0]  m_fn3, m_fid;
  int          m_out;
  bit          e_pop, e_valid;

  function automatic logic [31:0] rep(input logic [31:0] d, input logic [2:0] f);
    if (f[1:0] == 2'b00) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (f[1:0] == 2'b01) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit snoop_hit(input logic [2:0] id);
    return SNOOP && bus.wb_snoop.valid && bus.wb_snoop.id == id;
  endfunction

  task automatic model_reset();
    m_held = 0; m_have = 0; m_perr = 0; m_out = 0;
    m_addr = '0; m_data = '0; m_be = '0; m_fn3 = '0; m_fid = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input bit v, input logic [31:0] a, input logic [3:0] b, input logic [2:0] f,
                     input bit fw, input logic [31:0] d, input logic [2:0] id);
    bus.sq_valid = v;
    bus.sq_entry = {a, b, f, fw, d};
    bus.sq_forward_id = id;
  endtask

  task automatic wb(input bit v, input logic [2:0] id, input logic [31:0] d);
    bus.wb_snoop = {v, id, d};
  endtask

  task automatic look();
    @(negedge clk);
    e_pop   = rst_n && bus.sq_valid && !m_held && m_out < MAX;
    e_valid = m_held && m_have;
    chk("sq_pop", bus.sq_pop, e_pop);
    chk("mem_req_valid", bus.mem_req_valid, e_valid);
    chk("drain_idle", bus.drain_idle, !m_held && m_out == 0 && !bus.sq_valid);
    chk("protocol_error", bus.protocol_error, m_perr);
    if (e_valid) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_be", bus.mem_be, m_be);
      chk("mem_data", bus.mem_data, m_data);
    end
    if (!rst_n) begin
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_be", bus.mem_be, 0);
      chk("rst_data", bus.mem_data, 0);
    end
  endtask

  task automatic tick();
    bit hs;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      hs = e_valid && bus.mem_req_ready;
      if (hs) m_held = 0;
      else if (m_held && !m_have && snoop_hit(m_fid)) begin
        m_have = 1;
        m_data = rep(bus.wb_snoop.data, m_fn3);
      end
      if (e_pop) begin
        m_held = 1;
        m_addr = bus.sq_entry.addr;
        m_be   = bus.sq_entry.be;
        if (SNOOP && bus.sq_entry.forwarded_store) begin
          m_fid  = bus.sq_forward_id;
          m_fn3  = bus.sq_entry.fn3;
          m_have = snoop_hit(bus.sq_forward_id);
          if (m_have) m_data = rep(bus.wb_snoop.data, bus.sq_entry.fn3);
        end else begin
          m_have = 1;
          m_data = bus.sq_entry.data;
        end
      end
      if (bus.mem_ack && !hs) begin
        if (m_out == 0) m_perr = 1;
        else m_out--;
      end else if (hs && !bus.mem_ack) m_out++;
    end
    #1;
  endtask

  task automatic step();
    look();
    tick();
  endtask

  task automatic drain_acks();
    bus.mem_ack = 1'b1;
    while (m_out > 0) step();
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    put(1, 32'h1000, 4'hF, 3'd2, 0, 32'hDEAD_BEEF, 3'd0);
    wb(0, 3'd0, 32'h0);
    bus.mem_req_ready = 1'b1;
    bus.mem_ack = 1'b0;
    step(); step();
    rst_n = 1'b1;
    // single non-forwarded entry: pop, then request one cycle later
    look();
    chk("031_pop_c0", bus.sq_pop, 1);
    chk("031_valid_c0", bus.mem_req_valid, 0);
    tick();
    put(0, 32'h0, 4'h0, 3'd0, 0, 32'h0, 3'd0);
    look();
    chk("031_valid_c1", bus.mem_req_valid, 1);
    chk("031_addr", bus.mem_addr, 32'h1000);
    chk("031_data", bus.mem_data, 32'hDEAD_BEEF);
    tick();
    look();
    chk("031_busy", bus.drain_idle, 0);
    tick();
    drain_acks();
    // three entries with no acks: the third waits on the outstanding limit
    n = 0;
    for (int i = 0; i < 8; i++) begin
      put(n < 3, 32'h2000 + 32'(n) * 4, 4'hF, 3'd2, 0, 32'h1111_0000 + 32'(n), 3'd0);
      look();
      if (e_pop) n++;
      tick();
    end
    look();
    chk("033_blocked", bus.sq_pop, 0);
    tick();
    bus.mem_ack = 1'b1;
    look();
    chk("033_ack_cycle", bus.sq_pop, 0);
    tick();
    bus.mem_ack = 1'b0;
    look();
    chk("033_unblocked", bus.sq_pop, 1);
    tick();
    put(0, 32'h0, 4'h0, 3'd0, 0, 32'h0, 3'd0);
    step(); step();
    drain_acks();
    // backpressure holds valid and payload
    put(1, 32'h3000, 4'h3, 3'd1, 0, 32'hCAFE_F00D, 3'd0);
    bus.mem_req_ready = 1'b0;
    step();
    put(0, 32'h0, 4'h0, 3'd0, 0, 32'h0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      look();
      chk("034_hold_valid", bus.mem_req_valid, 1);
      chk("034_hold_addr", bus.mem_addr, 32'h3000);
      chk("034_hold_data", bus.mem_data, 32'hCAFE_F00D);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    step();
    look();
    chk("034_single", bus.mem_req_valid, 0);
    tick();
    drain_acks();
    // forwarded byte store
    put(1, 32'h4000, 4'h1, 3'b000, 1, 32'h1234_5678, 3'd3);
    step();
    put(0, 32'h0, 4'h0, 3'd0, 0, 32'h0, 3'd0);
`ifdef CVA5_STORE_FORWARD_SNOOP_EN
    wb(1, 3'd5, 32'h77);
    step();
    wb(0, 3'd3, 32'h0);
    step();
    wb(1, 3'd3, 32'h0000_00A5);
    look();
    chk("032_waiting", bus.mem_req_valid, 0);
    tick();
    wb(0, 3'd0, 32'h0);
    look();
    chk("032_valid", bus.mem_req_valid, 1);
    chk("032_data", bus.mem_data, 32'hA5A5_A5A5);
    tick();
`else
    look();
    chk("030_fwd_ignored", bus.mem_data, 32'h1234_5678);
    tick();
`endif
    drain_acks();
    // stray ack sets a sticky error
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    look();
    chk("035_perr", bus.protocol_error, 1);
    tick();
    step(); step();
    // reset in the middle of a held entry
    put(1, 32'h5000, 4'hF, 3'b000, 1, 32'h5555_5555, 3'd6);
    bus.mem_req_ready = 1'b0;
    step();
    put(0, 32'h0, 4'h0, 3'd0, 0, 32'h0, 3'd0);
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("036_valid", bus.mem_req_valid, 0);
    chk("036_addr", bus.mem_addr, 0);
    chk("036_data", bus.mem_data, 0);
    chk("036_perr", bus.protocol_error, 0);
    chk("036_pop", bus.sq_pop, 0);
    step(); step();
    rst_n = 1'b1;
    look();
    chk("036_drain_idle", bus.drain_idle, 1);
    tick();
    bus.mem_req_ready = 1'b1;
    put(1, 32'h6000, 4'hC, 3'd2, 0, 32'h0BAD_F00D, 3'd0);
    look();
    chk("028_first_pop", bus.sq_pop, 1);
    tick();
    put(0, 32'h0, 4'h0, 3'd0, 0, 32'h0, 3'd0);
    step();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (!bus.sq_valid || e_pop)
        put($urandom_range(3) != 0, $urandom, 4'($urandom), 3'($urandom), 1'($urandom),
            $urandom, 3'($urandom));
      wb(1'($urandom), 3'($urandom), $urandom);
      bus.mem_req_ready = $urandom_range(3) != 0;
      bus.mem_ack = m_out > 0 && $urandom_range(2) == 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
